// File: rtl/qmult_pkg.sv
// Shared constants and Q-format helpers for the fixed-point multiplier family.
// Widths are passed in so the helpers serve any N/Q instance.
package qmult_pkg;

    localparam int QM_N = 32;
    localparam int QM_Q = 18;

    localparam bit SAT_WRAP  = 1'b0;
    localparam bit SAT_CLAMP = 1'b1;

    localparam bit RND_TRUNC     = 1'b0;
    localparam bit RND_HALF_AWAY = 1'b1;

    function automatic logic [63:0] q_one(input int q);
        return 64'd1 << q;
    endfunction

    function automatic logic [63:0] max_pos(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative N-bit value (also its magnitude).
    function automatic logic [63:0] min_neg(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/qmult_round_sat.sv
// Rounds an unsigned magnitude product back to Q format, applies the sign,
// and flags / clamps results that do not fit in N bits.
module qmult_round_sat
    import qmult_pkg::*;
#(
    parameter int N = QM_N,
    parameter int Q = QM_Q
) (
    input  logic [2*N-1:0] p,
    input  logic           sign,
    input  logic           rnd,
    input  logic           sat,
    output logic [N-1:0]   result,
    output logic           ovr
);

    localparam int MW = 2*N - Q + 1;
    localparam logic [N-1:0] MAX_POS = N'(max_pos(N));
    localparam logic [N-1:0] MIN_NEG = N'(min_neg(N));

    logic [MW-1:0] m;
    logic [MW-1:0] lim;
    logic [N-1:0]  wrapped;

    always_comb begin
        m       = {1'b0, p[2*N-1:Q]} + MW'(rnd & p[Q-1]);
        lim     = sign ? MW'(MIN_NEG) : MW'(MAX_POS);
        ovr     = (m > lim);
        wrapped = sign ? -m[N-1:0] : m[N-1:0];
        result  = wrapped;
        if (m == '0) begin
            result = '0;
        end else if (ovr && sat) begin
            result = sign ? MIN_NEG : MAX_POS;
        end
    end

    // Bits below the rounding position never influence the result.
    if (Q > 1) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^p[Q-2:0];
    end

endmodule

// File: rtl/qmult_pipe.sv
// Three-stage signed Q-format multiplier with valid/ready streaming,
// selectable rounding, optional saturation and overflow flags.
module qmult_pipe
    import qmult_pkg::*;
#(
    parameter int N   = QM_N,
    parameter int Q   = QM_Q,
    parameter bit SAT = SAT_CLAMP,
    parameter bit RND = RND_TRUNC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] o_result,
    output logic         ovr,
    output logic         ovr_sticky,
    input  logic         clr_ovr
);

    logic en;

    logic           s1_valid_d, s1_valid_q;
    logic           s1_sign_d,  s1_sign_q;
    logic [N-1:0]   s1_ma_d,    s1_ma_q;
    logic [N-1:0]   s1_mb_d,    s1_mb_q;

    logic           s2_valid_d, s2_valid_q;
    logic           s2_sign_d,  s2_sign_q;
    logic [2*N-1:0] s2_p_d,     s2_p_q;

    logic           out_valid_d, out_valid_q;
    logic [N-1:0]   result_d,    result_q;
    logic           ovr_d,       ovr_q;
    logic           sticky_d,    sticky_q;

    logic [N-1:0]   rs_result;
    logic           rs_ovr;

    qmult_round_sat #(
        .N (N),
        .Q (Q)
    ) u_round_sat (
        .p      (s2_p_q),
        .sign   (s2_sign_q),
        .rnd    (RND),
        .sat    (SAT),
        .result (rs_result),
        .ovr    (rs_ovr)
    );

    // One enable for the whole pipe: a stalled output freezes every stage.
    assign en = !out_valid_q || out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_ma_d    = s1_ma_q;
        s1_mb_d    = s1_mb_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_sign_d  = a[N-1] ^ b[N-1];
            s1_ma_d    = a[N-1] ? -a : a;
            s1_mb_d    = b[N-1] ? -b : b;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_p_d     = s2_p_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_p_d     = (2*N)'(s1_ma_q) * (2*N)'(s1_mb_q);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovr_d       = ovr_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            result_d    = rs_result;
            ovr_d       = rs_ovr;
        end
    end

    // A new overflow reaching the consumer beats a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_valid_q && out_ready && ovr_q) begin
            sticky_d = 1'b1;
        end else if (clr_ovr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_p_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovr_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_p_q      <= s2_p_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovr_q       <= ovr_d;
            sticky_q    <= sticky_d;
        end
    end

    assign in_ready   = en;
    assign out_valid  = out_valid_q;
    assign o_result   = result_q;
    assign ovr        = ovr_q;
    assign ovr_sticky = sticky_q;

endmodule

// File: tb/tb_qmult_pipe.sv
// Bench for qmult_pipe: three instances (clamp/trunc, clamp/round, wrap/trunc)
// share one stimulus stream and are checked against an arithmetic model.
module tb_qmult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;
    logic        clr_ovr;

    logic        ir[3];
    logic        ov[3];
    logic        ovr_o[3];
    logic        stk[3];
    logic [31:0] res[3];

    always #5 clk = ~clk;

    qmult_pipe #(.N(32), .Q(18), .SAT(1'b1), .RND(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready),
        .o_result(res[0]), .ovr(ovr_o[0]), .ovr_sticky(stk[0]),
        .clr_ovr(clr_ovr)
    );

    qmult_pipe #(.N(32), .Q(18), .SAT(1'b1), .RND(1'b1)) u_rnd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready),
        .o_result(res[1]), .ovr(ovr_o[1]), .ovr_sticky(stk[1]),
        .clr_ovr(clr_ovr)
    );

    qmult_pipe #(.N(32), .Q(18), .SAT(1'b0), .RND(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready),
        .o_result(res[2]), .ovr(ovr_o[2]), .ovr_sticky(stk[2]),
        .clr_ovr(clr_ovr)
    );

    int checks = 0;
    int failures = 0;
    int delivered = 0;

    bit          m_stk[3];
    bit          prev_stall;
    logic [31:0] prev_res[3];
    logic        prev_ovr[3];

    logic [2:0][32:0] sb[$];

    localparam longint LIM = 64'sd2147483648;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Real-valued product scaled by 2^-18, rounded, then fitted to 32 bits.
    function automatic logic [32:0] model(input logic [31:0] va,
                                          input logic [31:0] vb,
                                          input bit sat, input bit rnd);
        longint p;
        longint r;
        bit     o;
        logic [31:0] v;
        p = longint'($signed(va)) * longint'($signed(vb));
        if (rnd) r = (p >= 0) ? (p + 131072) / 262144
                              : (p - 131072) / 262144;
        else     r = p / 262144;
        o = (r > LIM - 1) || (r < -LIM);
        v = r[31:0];
        if (o && sat) v = (r < 0) ? 32'h80000000 : 32'h7fffffff;
        return {o, v};
    endfunction

    function automatic logic [2:0][32:0] model3(input logic [31:0] va,
                                                input logic [31:0] vb);
        logic [2:0][32:0] e;
        e[0] = model(va, vb, 1'b1, 1'b0);
        e[1] = model(va, vb, 1'b1, 1'b1);
        e[2] = model(va, vb, 1'b0, 1'b0);
        return e;
    endfunction

    function automatic logic [31:0] rop();
        logic [31:0] v;
        logic [31:0] c[5];
        c = '{32'h80000000, 32'h7fffffff, 32'h0, 32'h00040000, 32'hfffc0000};
        v = $urandom;
        case ($urandom_range(0, 3))
            0:       return v;
            1, 2:    return {{10{v[21]}}, v[21:0]};
            default: return c[$urandom_range(0, 4)];
        endcase
    endfunction

    task automatic cycle(input bit iv, input logic [31:0] va,
                         input logic [31:0] vb, input bit ordy,
                         input bit clr);
        logic [2:0][32:0] e;
        bit popped;
        @(negedge clk);
        in_valid  = iv;
        a         = va;
        b         = vb;
        out_ready = ordy;
        clr_ovr   = clr;
        #1;
        popped = 1'b0;
        e = '0;
        if (ov[0] && ordy) begin
            if (sb.size() == 0) begin
                chk("spurious_out", ov[0], 0);
            end else begin
                e = sb.pop_front();
                popped = 1'b1;
                delivered++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sticky%0d", k), stk[k], m_stk[k]);
            chk($sformatf("in_ready%0d", k), ir[k], !ov[k] || ordy);
            chk($sformatf("valid_align%0d", k), ov[k], ov[0]);
            if (prev_stall) begin
                chk($sformatf("stall_valid%0d", k), ov[k], 1);
                chk($sformatf("stall_res%0d", k), res[k], prev_res[k]);
                chk($sformatf("stall_ovr%0d", k), ovr_o[k], prev_ovr[k]);
            end
            if (popped) begin
                chk($sformatf("result%0d", k), res[k], e[k][31:0]);
                chk($sformatf("ovr%0d", k), ovr_o[k], e[k][32]);
            end
            if (popped && e[k][32]) m_stk[k] = 1'b1;
            else if (clr)           m_stk[k] = 1'b0;
            prev_res[k] = res[k];
            prev_ovr[k] = ovr_o[k];
        end
        prev_stall = ov[0] && !ordy;
        if (iv && (!ov[0] || ordy)) sb.push_back(model3(va, vb));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || ov[0]) && n < 30) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic single(input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] r0, input bit o0,
                          input logic [31:0] r1, input bit o1,
                          input logic [31:0] r2, input bit o2,
                          input bit clr);
        int n;
        drain();
        cycle(1'b1, va, vb, 1'b1, clr);
        n = 0;
        do begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, clr);
            n++;
        end while (!ov[0] && n < 10);
        chk("latency", n, 3);
        chk("lit_res_sat", res[0], r0);
        chk("lit_ovr_sat", ovr_o[0], o0);
        chk("lit_res_rnd", res[1], r1);
        chk("lit_ovr_rnd", ovr_o[1], o1);
        chk("lit_res_wrap", res[2], r2);
        chk("lit_ovr_wrap", ovr_o[2], o2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] seen;
        logic [19:0] want;
        int d0;
        int cnt;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        clr_ovr = 1'b0;
        prev_stall = 1'b0;
        m_stk = '{0, 0, 0};
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", ov[k], 0);
            chk("rst_result", res[k], 0);
            chk("rst_ovr", ovr_o[k], 0);
            chk("rst_sticky", stk[k], 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ready_after_rst", ir[0], 1);

        single(32'h00060000, 32'hfff80000, 32'hfff40000, 0,
               32'hfff40000, 0, 32'hfff40000, 0, 1'b0);
        single(32'hffffffff, 32'h00020000, 32'h0, 0,
               32'hffffffff, 0, 32'h0, 0, 1'b0);
        single(32'h00000001, 32'h00020000, 32'h0, 0,
               32'h00000001, 0, 32'h0, 0, 1'b0);
        single(32'h02000000, 32'h02000000, 32'h7fffffff, 1,
               32'h7fffffff, 1, 32'h0, 1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sticky_after_ovr", stk[0], 1);
        single(32'h02000000, 32'hfe000000, 32'h80000000, 1,
               32'h80000000, 1, 32'h0, 1, 1'b0);
        single(32'hff000000, 32'h02000000, 32'h80000000, 0,
               32'h80000000, 0, 32'h80000000, 0, 1'b0);

        // back-to-back stream
        drain();
        for (int i = 0; i < 20; i++) begin
            cycle(i < 8, rop(), rop(), 1'b1, 1'b0);
            seen[i] = ov[0];
            want[i] = (i >= 3 && i <= 10);
        end
        chk("stream_valid", seen, want);

        // backpressure with three in flight
        drain();
        d0 = delivered;
        for (int i = 0; i < 3; i++) cycle(1'b1, rop(), rop(), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, rop(), rop(), 1'b0, 1'b0);
            chk("bp_in_ready", ir[0], 0);
        end
        drain();
        chk("bp_delivered", delivered - d0, 3);

        // sticky set beats clear
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sticky_cleared", stk[0], 0);
        single(32'h02000000, 32'h02000000, 32'h7fffffff, 1,
               32'h7fffffff, 1, 32'h0, 1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sticky_set_wins", stk[0], 1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sticky_clr_alone", stk[0], 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rop(), rop(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        drain();

        // asynchronous reset mid-stream
        single(32'h02000000, 32'hfe000000, 32'h80000000, 1,
               32'h80000000, 1, 32'h0, 1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, rop(), rop(), 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", ov[0], 1);
        chk("pre_rst_sticky", stk[0], 1);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_valid", ov[k], 0);
            chk("mid_rst_sticky", stk[k], 0);
            chk("mid_rst_result", res[k], 0);
        end
        sb.delete();
        m_stk = '{0, 0, 0};
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            if (ov[0]) cnt++;
        end
        chk("no_stale_after_rst", cnt, 0);
        chk("final_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qmult_pipe.md
Name: qmult_pipe

Overview:
- Pipelined, parametrised signed fixed-point multiplier. Two's-complement operands: N bits total, Q fraction bits.
- Successor to the combinational multiplier used in the Kalman datapath. Adds valid/ready streaming, 3-stage registered pipeline, selectable rounding, optional saturation, per-result and sticky overflow flags.
- Sits between Kalman matrix-element producers (predict/update sequencers) and the accumulate stage.

Parameters:
- N, 32, total word width (sign + integer + fraction).
- Q, 18, fraction bits; constraint 1 <= Q <= N-2.
- SAT, 1, 1 = clamp result on overflow; 0 = wrap (keep bits [N-1+Q:Q] of the signed product).
- RND, 0, 0 = truncate magnitude (round toward zero); 1 = round half away from zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  pipeline accepts a/b this cycle.
- a  in  N  signed Q-format operand.
- b  in  N  signed Q-format operand.
- out_valid  out  1  o_result/ovr valid.
- out_ready  in  1  downstream accepts result.
- o_result  out  N  signed Q-format product.
- ovr  out  1  overflow flag for the current result (qualified by out_valid).
- ovr_sticky  out  1  set by any accepted overflowed result; held until cleared.
- clr_ovr  in  1  synchronous clear of ovr_sticky.

Behaviour:
- Reset: asynchronous, active-high. Clears all stage valids, out_valid, o_result, ovr and ovr_sticky to 0. Data held in flight is discarded. in_ready=1 from the first cycle after reset deasserts.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational. All stages advance together when en=1 and hold when en=0. No bubble collapsing.
- Transfer rules: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput: 1 result/cycle.
- S1: register sign = a[N-1]^b[N-1], |a| and |b| as N-bit unsigned. -2^(N-1) gives magnitude 2^(N-1) exactly, with no wrap.
- S2: register the 2N-bit unsigned magnitude product P, plus sign.
- S3 rounding: M = P[2N-1:Q], plus P[Q-1] when RND=1.
- S3 limit: L = 2^(N-1)-1 when sign=0; L = 2^(N-1) when sign=1.
- S3 overflow: ovr = (M > L).
- S3 zero: M == 0 gives result 0 regardless of sign. Never a negative zero or -1 LSB.
- S3 result, no overflow: o_result = sign ? -M : M, over N bits.
- S3 result, overflow with SAT=1: 0x7FF..F for positive, 0x800..0 for negative.
- S3 result, overflow with SAT=0: low N bits of the signed value.
- ovr_sticky update on each clk:
  - Set when an output transfer occurs with ovr=1.
  - Otherwise cleared when clr_ovr=1.
  - Set wins when set and clear coincide.
- Stall: out_valid && !out_ready holds o_result and ovr stable, and in_ready=0. Inputs presented while in_ready=0 are not captured.

Decomposition:
- Shared package/header qmult_pkg:
  - Default N and Q.
  - SAT/RND mode localparams.
  - Q-format constant helpers: ONE = 1<<Q, MAX_POS, MIN_NEG.
- One natural sub-module, qmult_round_sat: the purely combinational S3 logic.
  - Inputs: P, sign, RND, SAT.
  - Outputs: result and ovr.
  - Reused later by the fixed-point adder/accumulator.

Test Plan (N=32, Q=18, SAT=1, RND=0 unless stated):
- Basic products: a=0x00060000 (1.5), b=0xFFF80000 (-2.0) -> o_result=0xFFF40000 (-3.0), ovr=0, 3 cycles after accept. Streaming 8 pairs back-to-back -> 8 consecutive out_valid cycles, in order.
- Rounding: a=0xFFFFFFFF (-2^-18), b=0x00020000 (0.5) -> RND=0: 0x00000000; RND=1: 0xFFFFFFFF. a=0x00000001, b=0x00020000 with RND=1 -> 0x00000001.
- Overflow and saturation:
  - a=b=0x02000000 (128.0) -> ovr=1, o_result=0x7FFFFFFF, ovr_sticky=1.
  - a=0x02000000, b=0xFE000000 -> 0x80000000, ovr=1.
  - a=0xFF000000 (-64), b=0x02000000 -> 0x80000000, ovr=0 (exact boundary).
  - With SAT=0, 128*128 -> 0x00000000 (wrapped), ovr=1.
- Backpressure: hold out_ready=0 for 5 cycles with 3 results in flight -> in_ready=0, o_result stable. Release -> all results delivered in order, none lost or duplicated.
- Sticky flag: overflowed result transferred in the same cycle as clr_ovr=1 -> ovr_sticky=1. clr_ovr=1 alone on a later cycle -> ovr_sticky=0.
- Reset mid-stream: assert rst with 3 valid stages in flight -> out_valid=0 and ovr_sticky=0 immediately (asynchronous). No stale result appears after rst deasserts.
